equiv_sweeper: RTL and testbench

EQUIV_SWEEPER -- requirements
Module: equiv_sweeper

---
 rtl/equiv_pkg.sv | 22 ++
 rtl/equiv_sweeper_settle_timer.sv | 39 +++
 rtl/equiv_sweeper.sv | 148 ++++++++++++++
 tb/tb_equiv_sweeper.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/equiv_pkg.sv
// equiv_pkg
// Shared definitions for the equivalence sweeper: FSM state encoding,
// default stimulus width and settle time, and the settle counter width.
// No ports; imported by equiv_sweeper and settle_timer.
package equiv_pkg;

  // Sweeper control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Default stimulus width and settle time (settle time legal range 1..255)
  localparam int DEF_VEC_W         = 4;
  localparam int DEF_SETTLE_CYCLES = 20;

  // The settle countdown is always 8 bits wide, enough for 255 cycles
  localparam int CNT_W = 8;

endpackage

// File: rtl/equiv_sweeper_settle_timer.sv
// settle_timer
// 8-bit down counter used to hold each stimulus vector for a fixed number of
// cycles before the responses are sampled.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset, clears the count to 0
//   i_load     load i_load_val into the counter (has priority over i_tick)
//   i_load_val reload value
//   i_tick     decrement by one; the count saturates at zero
//   o_zero     high when the count is zero
module settle_timer
  import equiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Counter register: a reload wins over a tick so that leaving CHECK and
  // starting a sweep both begin a fresh settle window; ticking stops at zero
  // so an idle tick can never wrap the count around to 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/equiv_sweeper.sv
// equiv_sweeper
// Walks a stimulus vector through every value 0..2^VEC_W-1, holds each value
// for SETTLE_CYCLES clocks, then compares the reference response with the
// minterm-form and maxterm-form responses. The first disagreement stops the
// sweep and latches which form(s) disagreed and on which vector.
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   start     one-cycle request to begin a sweep (ignored while busy)
//   vec_out   registered stimulus driven to both implementations
//   resp_in   bit0 reference, bit1 minterm form, bit2 maxterm form
//   busy      sweep in progress
//   done      sweep finished; held until the next accepted start or reset
//   pass      with done: every vector matched
//   fail_min  with done: reference and minterm form disagreed
//   fail_max  with done: reference and maxterm form disagreed
//   fail_vec  with done and !pass: the vector that disagreed
module equiv_sweeper
  import equiv_pkg::*;
#(
  parameter int VEC_W         = DEF_VEC_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] vec_out,
  input  logic [2:0]       resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail_min,
  output logic             fail_max,
  output logic [VEC_W-1:0] fail_vec
);

  // SETTLE is entered with the count at SETTLE_CYCLES-1 and leaves when it
  // reaches zero, which makes the settle window exactly SETTLE_CYCLES long.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = {VEC_W{1'b1}};

  state_t           r_state;
  logic [VEC_W-1:0] r_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail_min;
  logic             r_fail_max;
  logic [VEC_W-1:0] r_fail_vec;

  logic w_min_err;
  logic w_max_err;
  logic w_err;
  logic w_accept;
  logic w_advance;
  logic w_load;
  logic w_tick;
  logic w_zero;

  // Response comparison; resp_in is only looked at during the CHECK cycle,
  // after the settle window, so it is used without a synchronizer.
  assign w_min_err = resp_in[0] ^ resp_in[1];
  assign w_max_err = resp_in[0] ^ resp_in[2];
  assign w_err     = w_min_err | w_max_err;

  // A start is honoured only from IDLE or DONE; the counter is reloaded on
  // that edge and again whenever CHECK moves on to the next vector.
  assign w_accept  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_advance = (r_state == ST_CHECK) && !w_err && (r_vec != LAST_VEC);
  assign w_load    = w_accept | w_advance;
  assign w_tick    = (r_state == ST_SETTLE);

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_tick     (w_tick),
    .o_zero     (w_zero)
  );

  // Sweep controller. Every output is a register so vec_out only moves on the
  // start edge or the edge leaving CHECK, and the verdict stays frozen in DONE.
  // The all-ones vector ends the sweep instead of wrapping back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_vec      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_min <= 1'b0;
      r_fail_max <= 1'b0;
      r_fail_vec <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_vec      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_min <= 1'b0;
            r_fail_max <= 1'b0;
            r_fail_vec <= '0;
            r_state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_zero) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_err) begin
            r_fail_min <= w_min_err;
            r_fail_max <= w_max_err;
            r_fail_vec <= r_vec;
            r_pass     <= 1'b0;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_DONE;
          end else if (r_vec != LAST_VEC) begin
            r_vec   <= r_vec + 1'b1;
            r_state <= ST_SETTLE;
          end else begin
            r_pass  <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign vec_out  = r_vec;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail_min = r_fail_min;
  assign fail_max = r_fail_max;
  assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_equiv_sweeper.sv
// tb_equiv_sweeper
// Drives two sweepers (default settle time and a one-cycle settle time) with a
// simple AND-OR reference function; per-vector fault masks invert the minterm
// or maxterm response. Latency is counted in clock edges from the edge just
// before start is raised, so a start raised after edge S is accepted at S+1.
module tb_equiv_sweeper;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic [3:0] vec0, vec1, failVec0, failVec1;
  logic [2:0] resp0, resp1;
  logic busy0, done0, pass0, failMin0, failMax0;
  logic busy1, done1, pass1, failMin1, failMax1;
  logic [15:0] minMask0, maxMask0, minMask1, maxMask1;

  int compared = 0;
  int mismatched = 0;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Reference function both implementations are supposed to realise
  function automatic logic refFn(input logic [3:0] v);
    return (v[0] & v[1]) | (v[2] & v[3]);
  endfunction

  // Implementations under comparison: a set mask bit inverts that form on that vector
  always_comb begin
    resp0[0] = refFn(vec0);
    resp0[1] = refFn(vec0) ^ minMask0[vec0];
    resp0[2] = refFn(vec0) ^ maxMask0[vec0];
    resp1[0] = refFn(vec1);
    resp1[1] = refFn(vec1) ^ minMask1[vec1];
    resp1[2] = refFn(vec1) ^ maxMask1[vec1];
  end

  equiv_sweeper #(.VEC_W(4), .SETTLE_CYCLES(20)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_out(vec0), .resp_in(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_min(failMin0),
    .fail_max(failMax0), .fail_vec(failVec0)
  );

  equiv_sweeper #(.VEC_W(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec1), .resp_in(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_min(failMin1),
    .fail_max(failMax1), .fail_vec(failVec1)
  );

  typedef struct {
    string       name;
    int          which;
    logic [15:0] mn;
    logic [15:0] mx;
    int          pulseVec;
    bit          expPass;
    bit          expMin;
    bit          expMax;
    logic [3:0]  expVec;
    int          expLat;
  } vec_t;

  // Case-inequality compare so X/Z on an output counts as a mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setStart(input int which, input logic val);
    if (which == 0) start0 = val;
    else start1 = val;
  endtask

  task automatic snap(input int which, output logic [3:0] v, output logic b, output logic d,
                      output logic p, output logic fmn, output logic fmx, output logic [3:0] fv);
    if (which == 0) begin
      v = vec0; b = busy0; d = done0; p = pass0; fmn = failMin0; fmx = failMax0; fv = failVec0;
    end else begin
      v = vec1; b = busy1; d = done1; p = pass1; fmn = failMin1; fmx = failMax1; fv = failVec1;
    end
  endtask

  // Behavioural model: the first vector with any inverted form ends the sweep;
  // each vector costs settle+1 cycles, plus one cycle for accepting start.
  task automatic modelSweep(input logic [15:0] mn, input logic [15:0] mx, input int sc,
                            output bit p, output bit fmn, output bit fmx,
                            output logic [3:0] fv, output int lat);
    p = 1'b1; fmn = 1'b0; fmx = 1'b0; fv = 4'hF; lat = 1 + 16 * (sc + 1);
    for (int v = 0; v < 16; v++) begin
      if (mn[v] | mx[v]) begin
        p = 1'b0; fmn = mn[v]; fmx = mx[v]; fv = 4'(v); lat = 1 + (v + 1) * (sc + 1);
        break;
      end
    end
  endtask

  // Run one sweep; optionally re-pulse start once vec_out reaches pulseVec,
  // optionally release reset on the very edge start is raised.
  task automatic applyStimulus(input string tag, input int which, input logic [15:0] mn,
                               input logic [15:0] mx, input int pulseVec, input bit releaseRst,
                               input bit expPass, input bit expMin, input bit expMax,
                               input logic [3:0] expVec, input int expLat);
    int sc;
    int lat;
    int pulseLat;
    logic [3:0] v, fv;
    logic b, d, p, fmn, fmx;
    sc = (which == 0) ? 20 : 1;
    if (which == 0) begin minMask0 = mn; maxMask0 = mx; end
    else begin minMask1 = mn; maxMask1 = mx; end
    @(posedge clk);
    #1;
    if (releaseRst) rst = 1'b0;
    setStart(which, 1'b1);
    lat = 0;
    pulseLat = -1;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      setStart(which, 1'b0);
      snap(which, v, b, d, p, fmn, fmx, fv);
      if (lat == 1) checkOutput({tag, " busy"}, 32'(b), 32'd1);
      if (pulseLat >= 0 && lat == pulseLat + 1) checkOutput({tag, " restart_ignored"}, 32'(v), 32'(pulseVec));
      if (d) break;
      if (lat < expLat && (lat % 7) == 0) checkOutput({tag, " vec_progress"}, 32'(v), 32'((lat - 1) / (sc + 1)));
      if (pulseLat < 0 && pulseVec >= 0 && b && v == 4'(pulseVec)) begin
        setStart(which, 1'b1);
        pulseLat = lat;
      end
      if (lat > expLat + 5) begin
        checkOutput({tag, " done_timeout"}, 32'(d), 32'd1);
        break;
      end
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " pass"}, 32'(p), 32'(expPass));
    checkOutput({tag, " fail_min"}, 32'(fmn), 32'(expMin));
    checkOutput({tag, " fail_max"}, 32'(fmx), 32'(expMax));
    checkOutput({tag, " busy_end"}, 32'(b), 32'd0);
    checkOutput({tag, " vec_out"}, 32'(v), 32'(expVec));
    checkOutput({tag, " fail_vec"}, 32'(fv), expPass ? 32'd0 : 32'(expVec));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " vec_out"}, 32'(vec0), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy0), 32'd0);
    checkOutput({tag, " done"}, 32'(done0), 32'd0);
    checkOutput({tag, " pass"}, 32'(pass0), 32'd0);
    checkOutput({tag, " fail_min"}, 32'(failMin0), 32'd0);
    checkOutput({tag, " fail_max"}, 32'(failMax0), 32'd0);
    checkOutput({tag, " fail_vec"}, 32'(failVec0), 32'd0);
    checkOutput({tag, " dut1_done"}, 32'(done1), 32'd0);
  endtask

  // Hard stop in case something wedges the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[7];
    bit p, fmn, fmx;
    logic [3:0] fv;
    int lat, which, mode, waited;
    logic [15:0] mn, mx;

    tbl[0] = '{"clean",      0, 16'h0000, 16'h0000, -1, 1'b1, 1'b0, 1'b0, 4'hF, 337};
    tbl[1] = '{"min_at_9",   0, 16'h0200, 16'h0000, -1, 1'b0, 1'b1, 1'b0, 4'h9, 211};
    tbl[2] = '{"both_at_0",  0, 16'h0001, 16'h0001, -1, 1'b0, 1'b1, 1'b1, 4'h0, 22};
    tbl[3] = '{"max_at_3",   0, 16'h0080, 16'h0008, -1, 1'b0, 1'b0, 1'b1, 4'h3, 85};
    tbl[4] = '{"restart_5",  0, 16'h0000, 16'h0000,  5, 1'b1, 1'b0, 1'b0, 4'hF, 337};
    tbl[5] = '{"sc1_clean",  1, 16'h0000, 16'h0000, -1, 1'b1, 1'b0, 1'b0, 4'hF, 33};
    tbl[6] = '{"sc1_min_15", 1, 16'h8000, 16'h0000, -1, 1'b0, 1'b1, 1'b0, 4'hF, 33};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    minMask0 = '0; maxMask0 = '0; minMask1 = '0; maxMask1 = '0;
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].name, tbl[i].which, tbl[i].mn, tbl[i].mx, tbl[i].pulseVec, 1'b0,
                    tbl[i].expPass, tbl[i].expMin, tbl[i].expMax, tbl[i].expVec, tbl[i].expLat);
    end

    // Randomized fault patterns checked against the model
    for (int i = 0; i < 6; i++) begin
      which = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 2));
      mn = '0; mx = '0;
      if (mode == 1) begin
        mn[$urandom_range(0, 15)] = ($urandom_range(0, 1) == 1);
        mx[$urandom_range(0, 15)] = ($urandom_range(0, 1) == 1);
      end else if (mode == 2) begin
        mn = 16'($urandom) & 16'($urandom) & 16'($urandom);
        mx = 16'($urandom) & 16'($urandom) & 16'($urandom);
      end
      modelSweep(mn, mx, (which == 0) ? 20 : 1, p, fmn, fmx, fv, lat);
      $display("[TB] random %0d dut%0d min=%h max=%h", i, which, mn, mx);
      applyStimulus($sformatf("rand%0d", i), which, mn, mx, -1, 1'b0, p, fmn, fmx, fv, lat);
    end

    // Reset in the middle of a sweep, then a start on the first edge after release
    minMask0 = '0; maxMask0 = '0;
    @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    waited = 0;
    while (vec0 != 4'hA && waited < 400) begin
      @(posedge clk);
      #1 waited++;
    end
    checkOutput("reach_vec_A", 32'(vec0), 32'hA);
    #2 rst = 1'b1;
    #1 checkResetState("mid_reset");
    applyStimulus("after_reset", 0, 16'h0000, 16'h0000, -1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 337);

    // Verdict must stay frozen while idle in DONE
    repeat (5) @(posedge clk);
    #1;
    checkOutput("hold_done", 32'(done0), 32'd1);
    checkOutput("hold_pass", 32'(pass0), 32'd1);
    checkOutput("hold_vec", 32'(vec0), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
